// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit. The control unit imports
// this package too: the op encodings and FSM states are common to both.
package mdu_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_RUN  = 3'd2,
      S_FIX  = 3'd3,
      S_DZ   = 3'd4
   } state_t;

   // True for DIV and DIVU.
   function automatic logic op_is_div(input logic [1:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // True for the two's-complement variants (MULT and DIV).
   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/mdu_cneg.sv
// Conditional two's-complement negator. It turns operands into magnitudes
// and puts the sign back on results.
module mdu_cneg #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] val_i,
   input  logic             neg_i,
   output logic [WIDTH-1:0] val_o
);

   // Pass the value through, or invert it and add one.
   always_comb begin
      if (neg_i) begin
         val_o = (~val_i) + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         val_o = val_i;
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit. It owns HI/LO, handles one bit per cycle
// and handshakes through start/busy/done. All outputs are registered.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_t                 state_q, state_d;
   logic [1:0]             op_q, op_d;
   logic [WIDTH-1:0]       a_q, a_d;        // multiplicand / dividend (magnitude after LOAD)
   logic [WIDTH-1:0]       b_q, b_d;        // multiplier (shifted out) / divisor
   logic [2*WIDTH-1:0]     acc_q, acc_d;    // product, or {remainder, quotient}
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   neg_res_q, neg_res_d;  // product / quotient sign
   logic                   neg_rem_q, neg_rem_d;  // remainder follows the dividend
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   dz_q, dz_d;
   logic [WIDTH-1:0]       hi_q, hi_d;
   logic [WIDTH-1:0]       lo_q, lo_d;

   logic                   a_neg_s, b_neg_s;
   logic [WIDTH-1:0]       a_mag_s, b_mag_s;
   logic [2*WIDTH-1:0]     prod_s;
   logic [WIDTH-1:0]       quo_s, rem_s;
   logic [WIDTH:0]         add_s;
   logic [WIDTH:0]         trial_s;
   logic [2*WIDTH-1:0]     mul_acc_s, div_acc_s;

   assign a_neg_s = op_is_signed(op_q) & a_q[WIDTH-1];
   assign b_neg_s = op_is_signed(op_q) & b_q[WIDTH-1];

   mdu_cneg #(.WIDTH(WIDTH)) u_neg_a (.val_i(a_q), .neg_i(a_neg_s), .val_o(a_mag_s));
   mdu_cneg #(.WIDTH(WIDTH)) u_neg_b (.val_i(b_q), .neg_i(b_neg_s), .val_o(b_mag_s));
   mdu_cneg #(.WIDTH(2*WIDTH)) u_neg_prod (.val_i(acc_q), .neg_i(neg_res_q), .val_o(prod_s));
   mdu_cneg #(.WIDTH(WIDTH)) u_neg_quo (.val_i(acc_q[WIDTH-1:0]), .neg_i(neg_res_q), .val_o(quo_s));
   mdu_cneg #(.WIDTH(WIDTH)) u_neg_rem (.val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(neg_rem_q), .val_o(rem_s));

   // One iteration of each algorithm: shift-add multiply, restoring divide.
   always_comb begin
      if (b_q[0]) begin
         add_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
      end else begin
         add_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      end
      mul_acc_s = {add_s, acc_q[WIDTH-1:1]};

      trial_s = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
      if (!trial_s[WIDTH]) begin
         div_acc_s = {trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         div_acc_s = {acc_q[2*WIDTH-2:0], 1'b0};
      end
   end

   // Next-state and datapath updates for every FSM state.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dz_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d = op;
               a_d  = op_a;
               b_d  = op_b;
               if (op_is_div(op) && (op_b == {WIDTH{1'b0}})) begin
                  state_d = S_DZ;
               end else begin
                  state_d = S_LOAD;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            a_d       = a_mag_s;
            b_d       = b_mag_s;
            neg_res_d = a_neg_s ^ b_neg_s;
            neg_rem_d = a_neg_s;
            cnt_d     = CNT_W'(WIDTH);
            if (op_is_div(op_q)) begin
               acc_d = {{WIDTH{1'b0}}, a_mag_s};
            end else begin
               acc_d = {(2*WIDTH){1'b0}};
            end
            state_d = S_RUN;
         end
         S_RUN: begin
            if (op_is_div(op_q)) begin
               acc_d = div_acc_s;
            end else begin
               acc_d = mul_acc_s;
               b_d   = {1'b0, b_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_FIX;
            end else begin
               state_d = S_RUN;
            end
         end
         S_FIX: begin
            if (op_is_div(op_q)) begin
               hi_d = rem_s;
               lo_d = quo_s;
            end else begin
               hi_d = prod_s[2*WIDTH-1:WIDTH];
               lo_d = prod_s[WIDTH-1:0];
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         S_DZ: begin
            done_d  = 1'b1;
            dz_d    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // All FSM and datapath state. A synchronous reset aborts any operation.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         op_q      <= 2'b00;
         a_q       <= {WIDTH{1'b0}};
         b_q       <= {WIDTH{1'b0}};
         acc_q     <= {(2*WIDTH){1'b0}};
         cnt_q     <= {CNT_W{1'b0}};
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
         hi_q      <= {WIDTH{1'b0}};
         lo_q      <= {WIDTH{1'b0}};
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dz_q      <= dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a 32-bit instance plus an 8-bit instance.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        rst32, rst8, start32, start8;
   logic [1:0]  op32, op8;
   logic [31:0] a32, b32, hi32, lo32;
   logic [7:0]  a8, b8, hi8, lo8;
   logic        busy32, done32, dz32, busy8, done8, dz8;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   mult_div_unit #(.WIDTH(32)) dut32 (
      .clock(clk), .reset(rst32), .start(start32), .op(op32), .op_a(a32), .op_b(b32),
      .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
   );

   mult_div_unit #(.WIDTH(8)) dut8 (
      .clock(clk), .reset(rst8), .start(start8), .op(op8), .op_a(a8), .op_b(b8),
      .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one edge (E0) on the selected instance.
   task automatic issue(input bit sel, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      if (sel) begin
         start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
      end else begin
         start32 = 1'b1; op32 = op; a32 = a; b32 = b;
      end
      tick();
      start8 = 1'b0;
      start32 = 1'b0;
   endtask

   // Count edges until done appears (bounded); lat=-1 on timeout. busy must be high until then.
   task automatic wait_done(input bit sel, output int lat, output bit busy_ok);
      int n;
      n = 0;
      lat = -1;
      busy_ok = 1'b1;
      while (n < 200) begin
         if ((sel ? done8 : done32) === 1'b1) begin
            lat = n;
            break;
         end
         if ((sel ? busy8 : busy32) !== 1'b1) busy_ok = 1'b0;
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst32 = 1'b0; rst8 = 1'b0; start32 = 1'b0; start8 = 1'b0;
      op32 = 2'b00; op8 = 2'b00; a32 = 32'h0; b32 = 32'h0; a8 = 8'h0; b8 = 8'h0;
      tick();
      tick();
      checks++;
      if ({busy32, done32, dz32, hi32, lo32} !== 67'h0) begin
         failures++;
         $display("FAIL reset32 got=%h exp=0", {busy32, done32, dz32, hi32, lo32});
      end
      checks++;
      if ({busy8, done8, dz8, hi8, lo8} !== 19'h0) begin
         failures++;
         $display("FAIL reset8 got=%h exp=0", {busy8, done8, dz8, hi8, lo8});
      end
      rst32 = 1'b1; rst8 = 1'b1;
      tick();
   endtask

   task automatic test_mult();
      int lat; bit bok;
      issue(1'b0, 2'b00, 32'hFFFFFFFD, 32'h00000005);
      wait_done(1'b0, lat, bok);
      checks++;
      if (lat !== 34 || !bok || busy32 !== 1'b0) begin
         failures++;
         $display("FAIL mult_timing got lat=%0d busy_ok=%0d busy=%b exp lat=34 busy_ok=1 busy=0", lat, bok, busy32);
      end
      checks++;
      if ({hi32, lo32, dz32} !== {64'hFFFFFFFF_FFFFFFF1, 1'b0}) begin
         failures++;
         $display("FAIL mult_result got=%h_%h dz=%b exp=FFFFFFFF_FFFFFFF1 dz=0", hi32, lo32, dz32);
      end
      tick();
      checks++;
      if (done32 !== 1'b0) begin
         failures++;
         $display("FAIL mult_done_pulse got=%b exp=0", done32);
      end
      issue(1'b0, 2'b00, 32'h80000000, 32'h80000000);
      wait_done(1'b0, lat, bok);
      checks++;
      if (lat !== 34 || {hi32, lo32} !== 64'h40000000_00000000) begin
         failures++;
         $display("FAIL mult_min got lat=%0d %h_%h exp lat=34 40000000_00000000", lat, hi32, lo32);
      end
      tick();
   endtask

   task automatic test_multu();
      int lat; bit bok;
      issue(1'b0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(1'b0, lat, bok);
      checks++;
      if (lat !== 34 || !bok || {hi32, lo32} !== 64'hFFFFFFFE_00000001) begin
         failures++;
         $display("FAIL multu got lat=%0d busy_ok=%0d %h_%h exp lat=34 FFFFFFFE_00000001", lat, bok, hi32, lo32);
      end
      tick();
   endtask

   task automatic test_div();
      int lat; bit bok;
      issue(1'b0, 2'b10, 32'hFFFFFFF9, 32'h00000002);
      wait_done(1'b0, lat, bok);
      checks++;
      if (lat !== 34 || !bok || {hi32, lo32, dz32} !== {64'hFFFFFFFF_FFFFFFFD, 1'b0}) begin
         failures++;
         $display("FAIL div_neg got lat=%0d busy_ok=%0d hi=%h lo=%h dz=%b exp lat=34 hi=FFFFFFFF lo=FFFFFFFD dz=0", lat, bok, hi32, lo32, dz32);
      end
      tick();
      issue(1'b0, 2'b10, 32'h80000000, 32'hFFFFFFFF);
      wait_done(1'b0, lat, bok);
      checks++;
      if (lat !== 34 || {hi32, lo32} !== 64'h00000000_80000000) begin
         failures++;
         $display("FAIL div_min got lat=%0d hi=%h lo=%h exp lat=34 hi=00000000 lo=80000000", lat, hi32, lo32);
      end
      tick();
   endtask

   task automatic test_div_zero();
      int lat; bit bok;
      issue(1'b0, 2'b11, 32'h56781234, 32'h00010000);
      wait_done(1'b0, lat, bok);
      checks++;
      if (lat !== 34 || {hi32, lo32} !== 64'h00001234_00005678) begin
         failures++;
         $display("FAIL divu_setup got lat=%0d hi=%h lo=%h exp lat=34 hi=00001234 lo=00005678", lat, hi32, lo32);
      end
      tick();
      issue(1'b0, 2'b11, 32'h00000007, 32'h00000000);
      wait_done(1'b0, lat, bok);
      checks++;
      if (lat !== 1 || !bok || dz32 !== 1'b1 || busy32 !== 1'b0) begin
         failures++;
         $display("FAIL dz_timing got lat=%0d busy_ok=%0d dz=%b busy=%b exp lat=1 busy_ok=1 dz=1 busy=0", lat, bok, dz32, busy32);
      end
      checks++;
      if ({hi32, lo32} !== 64'h00001234_00005678) begin
         failures++;
         $display("FAIL dz_hold got hi=%h lo=%h exp hi=00001234 lo=00005678", hi32, lo32);
      end
      tick();
      checks++;
      if ({done32, dz32} !== 2'b00) begin
         failures++;
         $display("FAIL dz_pulse got done=%b dz=%b exp 0 0", done32, dz32);
      end
   endtask

   task automatic test_ignore_start();
      int lat; bit bok;
      issue(1'b0, 2'b11, 32'd100, 32'd7);
      repeat (5) tick();
      start32 = 1'b1; op32 = 2'b01; a32 = 32'd3; b32 = 32'd3;
      tick();
      start32 = 1'b0;
      wait_done(1'b0, lat, bok);
      checks++;
      if (lat !== 28 || !bok || {hi32, lo32} !== {32'd2, 32'd14}) begin
         failures++;
         $display("FAIL ignore_start got lat=%0d busy_ok=%0d hi=%h lo=%h exp lat=28 hi=2 lo=e", lat, bok, hi32, lo32);
      end
      tick();
      tick();
      checks++;
      if ({busy32, done32} !== 2'b00) begin
         failures++;
         $display("FAIL ignore_idle got busy=%b done=%b exp 0 0", busy32, done32);
      end
   endtask

   task automatic test_back_to_back();
      int lat; bit bok;
      issue(1'b0, 2'b01, 32'd6, 32'd7);
      wait_done(1'b0, lat, bok);
      start32 = 1'b1; op32 = 2'b00; a32 = 32'hFFFFFFFE; b32 = 32'hFFFFFFFD;
      tick();
      start32 = 1'b0;
      checks++;
      if (lat !== 34 || {hi32, lo32} !== 64'd42 || {busy32, done32} !== 2'b10) begin
         failures++;
         $display("FAIL b2b_first got lat=%0d %h_%h busy=%b done=%b exp lat=34 0_2a busy=1 done=0", lat, hi32, lo32, busy32, done32);
      end
      wait_done(1'b0, lat, bok);
      checks++;
      if (lat !== 34 || !bok || {hi32, lo32} !== 64'd6) begin
         failures++;
         $display("FAIL b2b_second got lat=%0d busy_ok=%0d %h_%h exp lat=34 0_6", lat, bok, hi32, lo32);
      end
      tick();
   endtask

   task automatic test_mid_reset();
      bit seen;
      seen = 1'b0;
      issue(1'b0, 2'b01, 32'd9, 32'd9);
      repeat (10) tick();
      rst32 = 1'b0;
      tick();
      checks++;
      if ({busy32, done32, hi32, lo32} !== 66'h0) begin
         failures++;
         $display("FAIL mid_reset got busy=%b done=%b hi=%h lo=%h exp all 0", busy32, done32, hi32, lo32);
      end
      rst32 = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (done32 !== 1'b0 || busy32 !== 1'b0) seen = 1'b1;
         tick();
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_quiet got activity=%b exp 0", seen);
      end
   endtask

   task automatic test_width8();
      int lat; bit bok;
      issue(1'b1, 2'b00, 32'h80, 32'h80);
      wait_done(1'b1, lat, bok);
      checks++;
      if (lat !== 10 || !bok || {hi8, lo8} !== 16'h4000) begin
         failures++;
         $display("FAIL w8_mult got lat=%0d busy_ok=%0d hi=%h lo=%h exp lat=10 hi=40 lo=00", lat, bok, hi8, lo8);
      end
      tick();
      issue(1'b1, 2'b11, 32'hFF, 32'h10);
      wait_done(1'b1, lat, bok);
      checks++;
      if (lat !== 10 || {hi8, lo8, dz8} !== {16'h0F0F, 1'b0}) begin
         failures++;
         $display("FAIL w8_divu got lat=%0d hi=%h lo=%h dz=%b exp lat=10 hi=0f lo=0f dz=0", lat, hi8, lo8, dz8);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_div_zero();
      test_ignore_start();
      test_back_to_back();
      test_mid_reset();
      test_width8();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
